// File: rtl/iaram_rx_pkg.sv
// Shared types and constants for the DRAM-to-IARAM stream receiver.
// Optional error detection is enabled by defining IARAM_RX_ERR_CHECK_EN.
package iaram_rx_pkg;

    localparam int LANES  = 4;
    localparam int NUM_CH = 3;
    localparam int DEPTH  = 64;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 4;

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int N_W    = $clog2(LANES + 1);
    localparam int ERR_W  = 3;

    localparam int ERR_GAP = 0;
    localparam int ERR_IDX = 1;
    localparam int ERR_OVF = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_INDEX = 2'd2,
        S_READY = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [LANES-1:0]             valid;
        logic [LANES-1:0][DATA_W-1:0] data;
        logic                         dense;
        logic [CH_W-1:0]              channel;
    } rx_beat_t;

    typedef struct packed {
        logic [LANES-1:0]            valid;
        logic [LANES-1:0][IDX_W-1:0] data;
        logic [CH_W-1:0]             channel;
    } rx_idx_beat_t;

    function automatic logic ch_in_range(input logic [CH_W-1:0] ch);
        return ({1'b0, ch} < (CH_W + 1)'(NUM_CH));
    endfunction

endpackage

// File: rtl/iaram_rx_lane_packer.sv
// Turns a lane valid mask plus a bank write pointer into per-lane write enables/addresses,
// the saturated next pointer, and overflow/gap flags (used by IARAM_RX_ERR_CHECK_EN builds).
module iaram_rx_lane_packer
    import iaram_rx_pkg::*;
(
    input  logic [LANES-1:0]             valid_i,
    input  logic [CNT_W-1:0]             base_i,
    output logic [LANES-1:0]             we_o,
    output logic [LANES-1:0][ADDR_W-1:0] addr_o,
    output logic [CNT_W-1:0]             next_o,
    output logic                         ovf_o,
    output logic                         gap_o
);

    logic [N_W-1:0] n_s;
    logic [CNT_W:0] sum_s;

    // Count leading valid lanes; any valid lane after the first hole is a gap
    always_comb begin : lane_count
        logic run_v;
        run_v = 1'b1;
        n_s   = '0;
        gap_o = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (!valid_i[i]) begin
                run_v = 1'b0;
            end else if (run_v) begin
                n_s = n_s + N_W'(1);
            end else begin
                gap_o = 1'b1;
            end
        end
    end

    // Lanes past the bank end are dropped and the pointer saturates at DEPTH
    always_comb begin : lane_addr
        logic [CNT_W:0] pos_v;
        pos_v  = '0;
        sum_s  = {1'b0, base_i} + (CNT_W + 1)'(n_s);
        ovf_o  = (sum_s > (CNT_W + 1)'(DEPTH));
        next_o = ovf_o ? CNT_W'(DEPTH) : sum_s[CNT_W-1:0];
        for (int i = 0; i < LANES; i++) begin
            pos_v     = {1'b0, base_i} + (CNT_W + 1)'(i);
            we_o[i]   = (N_W'(i) < n_s) && (pos_v < (CNT_W + 1)'(DEPTH));
            addr_o[i] = base_i[ADDR_W-1:0] + ADDR_W'(i);
        end
    end

endmodule

// File: rtl/iaram_stream_rx.sv
// PE-side endpoint of the activation DRAM stream: buffers data/index beats per channel
// and serves a 1-cycle read port. Define IARAM_RX_ERR_CHECK_EN to enable the err flags.
module iaram_stream_rx
    import iaram_rx_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES-1:0]          d_valid,
    input  logic [LANES*DATA_W-1:0]   d_data,
    input  logic                      d_dense,
    input  logic [CH_W-1:0]           d_channel,
    input  logic [LANES-1:0]          i_valid,
    input  logic [LANES*IDX_W-1:0]    i_data,
    input  logic [CH_W-1:0]           i_channel,
    input  logic                      stream_finish,
    input  logic                      clear,
    input  logic                      rd_en,
    input  logic [CH_W-1:0]           rd_channel,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic [IDX_W-1:0]          rd_index,
    output logic                      rd_valid,
    output logic [NUM_CH*CNT_W-1:0]   ch_count,
    output logic [NUM_CH-1:0]         ch_dense,
    output logic                      ready,
    output logic [ERR_W-1:0]          err
);

    logic [DATA_W-1:0] data_mem [NUM_CH][DEPTH];
    logic [IDX_W-1:0]  idx_mem  [NUM_CH][DEPTH];

    rx_state_e                      state_q;
    logic [CH_W-1:0]                cur_ch_q;
    logic [CNT_W-1:0]               d_wptr_q, i_wptr_q;
    logic [NUM_CH-1:0][CNT_W-1:0]   count_q;
    logic [NUM_CH-1:0]              dense_q;
    logic [ERR_W-1:0]               err_q, err_d;
    logic [DATA_W-1:0]              rd_data_q;
    logic [IDX_W-1:0]               rd_index_q;
    logic                           rd_valid_q;

    rx_beat_t                       d_beat_s;
    rx_idx_beat_t                   i_beat_s;
    logic                           in_stream_s, d_any_s, i_any_s, new_layer_s, ch_change_s, d_open_s, i_take_s;
    logic                           mismatch_s;
    logic [CNT_W-1:0]               d_base_s, d_next_s, i_next_s;
    logic [LANES-1:0]               d_we_s, i_we_s;
    logic [LANES-1:0][ADDR_W-1:0]   d_addr_s, i_addr_s;
    logic                           d_ovf_s, d_gap_s, i_ovf_s, i_gap_s;

    assign d_beat_s = {d_valid, d_data, d_dense, d_channel};
    assign i_beat_s = {i_valid, i_data, i_channel};

    assign in_stream_s = (state_q == S_DATA) || (state_q == S_INDEX);
    assign d_any_s     = (|d_beat_s.valid) && ch_in_range(d_beat_s.channel);
    assign i_any_s     = (|i_beat_s.valid) && ch_in_range(i_beat_s.channel);
    assign new_layer_s = d_any_s && !in_stream_s;
    assign ch_change_s = d_any_s && in_stream_s && (d_beat_s.channel != cur_ch_q);
    assign d_open_s    = new_layer_s || ch_change_s;
    assign d_base_s    = d_open_s ? '0 : d_wptr_q;
    // Index beats only land inside an open stream and never for dense channels
    assign i_take_s    = i_any_s && in_stream_s && !ch_change_s && !dense_q[i_beat_s.channel];
    assign mismatch_s  = ch_change_s && !dense_q[cur_ch_q] && (i_wptr_q != d_wptr_q);

    iaram_rx_lane_packer u_d_pack (
        .valid_i (d_beat_s.valid),
        .base_i  (d_base_s),
        .we_o    (d_we_s),
        .addr_o  (d_addr_s),
        .next_o  (d_next_s),
        .ovf_o   (d_ovf_s),
        .gap_o   (d_gap_s)
    );

    iaram_rx_lane_packer u_i_pack (
        .valid_i (i_beat_s.valid),
        .base_i  (i_wptr_q),
        .we_o    (i_we_s),
        .addr_o  (i_addr_s),
        .next_o  (i_next_s),
        .ovf_o   (i_ovf_s),
        .gap_o   (i_gap_s)
    );

`ifdef IARAM_RX_ERR_CHECK_EN
    // Sticky error accumulation
    always_comb begin
        err_d          = err_q;
        err_d[ERR_OVF] = err_q[ERR_OVF] | (d_any_s & d_ovf_s) | (i_take_s & i_ovf_s);
        err_d[ERR_IDX] = err_q[ERR_IDX] | mismatch_s;
        err_d[ERR_GAP] = err_q[ERR_GAP] | (d_any_s & d_gap_s) | (i_take_s & i_gap_s);
    end
`else
    logic err_unused_s;
    assign err_unused_s = ^{d_ovf_s, d_gap_s, i_ovf_s, i_gap_s, mismatch_s};
    assign err_d        = '0;
`endif

    // Stream FSM, per-channel bookkeeping and error register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cur_ch_q <= '0;
            d_wptr_q <= '0;
            i_wptr_q <= '0;
            count_q  <= '0;
            dense_q  <= '0;
            err_q    <= '0;
        end else if (clear) begin
            state_q  <= S_IDLE;
            d_wptr_q <= '0;
            i_wptr_q <= '0;
            count_q  <= '0;
            dense_q  <= '0;
            err_q    <= '0;
        end else begin
            err_q <= err_d;
            if (new_layer_s) begin
                count_q <= '0;
                dense_q <= '0;
            end
            if (d_any_s) begin
                cur_ch_q                   <= d_beat_s.channel;
                d_wptr_q                   <= d_next_s;
                count_q[d_beat_s.channel]  <= d_next_s;
                dense_q[d_beat_s.channel]  <= d_open_s ? d_beat_s.dense
                                                       : (dense_q[d_beat_s.channel] | d_beat_s.dense);
            end
            if (d_open_s) begin
                i_wptr_q <= '0;
            end else if (i_take_s) begin
                i_wptr_q <= i_next_s;
            end
            if (stream_finish) begin
                state_q <= S_READY;
            end else begin
                case (state_q)
                    S_IDLE:  if (d_any_s) state_q <= S_DATA;
                    S_DATA:  if (i_take_s) state_q <= S_INDEX;
                    S_INDEX: if (ch_change_s) state_q <= S_DATA;
                    S_READY: if (d_any_s) state_q <= S_DATA;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Bank writes; contents survive reset
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (!rst && !clear && d_any_s && d_we_s[l]) begin
                data_mem[d_beat_s.channel][d_addr_s[l]] <= d_beat_s.data[l];
            end
            if (!rst && !clear && i_take_s && i_we_s[l]) begin
                idx_mem[i_beat_s.channel][i_addr_s[l]] <= i_beat_s.data[l];
            end
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_index_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en && ch_in_range(rd_channel) && ({1'b0, rd_addr} < count_q[rd_channel]);
            if (rd_en) begin
                rd_data_q  <= data_mem[rd_channel][rd_addr];
                rd_index_q <= dense_q[rd_channel] ? '0 : idx_mem[rd_channel][rd_addr];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_index = rd_index_q;
    assign rd_valid = rd_valid_q;
    assign ch_count = count_q;
    assign ch_dense = dense_q;
    assign ready    = (state_q == S_READY);
    assign err      = err_q;

endmodule
